clock_time_set_ctrl: RTL and testbench
======================================

Name: clock_time_set_ctrl

Overview:
Sequences the time-setting path of the digital clock. Debounces the hour and minute set buttons on reference-clock ticks and runs the set/run mode state machine. In run mode it issues a seconds increment on each 1 Hz strobe; in set mode it issues hour or minute increments on each time-set strobe. It drives the fast-set select back to the reference strobe generator, sitting between that generator and the time-of-day counters.

Parameters:
DEBOUNCE_TICKS, 64, refclk strobes a raw button level must hold before it is accepted (~2 ms at 32.768 kHz)
HOLD_STEPS, 4, slow-rate set increments issued before switching to fast rate
CNT_W, 8, width of debounce and step counters; must hold DEBOUNCE_TICKS and HOLD_STEPS

Ports:
i_clk  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_en  in  1  global enable; low freezes all state
i_refclk_stb  in  1  one-cycle strobe per refclk rising edge
i_1hz_stb  in  1  one-cycle strobe per second
i_timeset_stb  in  1  one-cycle strobe at the slow or fast set rate
i_btn_hours  in  1  raw hour-set button, asynchronous, active high
i_btn_minutes  in  1  raw minute-set button, asynchronous, active high
o_fast_set  out  1  level; selects the fast set rate in the strobe generator
o_inc_sec  out  1  one-cycle seconds increment strobe
o_inc_min  out  1  one-cycle minutes increment strobe
o_inc_hour  out  1  one-cycle hours increment strobe
o_clr_sec  out  1  one-cycle seconds-clear strobe
o_setting  out  1  level; high in either set state

Behaviour:
- Reset: all registers and outputs 0, state RUN, debounced levels 0. Reset takes effect asynchronously; release is synchronous to i_clk.
- i_en low: nothing updates and all strobe outputs are 0. Level outputs hold their value.
- Button sync: each raw button passes through a 2-flop synchronizer clocked every i_clk.
- Debounce:
  - The per-button counter increments on i_refclk_stb while the synced level differs from the debounced level.
  - It clears whenever the two levels match.
  - On reaching DEBOUNCE_TICKS, the debounced level takes the synced level and the counter clears.
  - Press and release are each one-cycle pulses derived from the debounced level.
- State RUN:
  - o_inc_sec is i_1hz_stb registered (1-cycle latency).
  - A hours press moves to SET_HR. A minutes press moves to SET_MIN.
  - Simultaneous presses: hours wins.
- Entry to SET_HR or SET_MIN:
  - In the cycle after the press, exactly one increment of the selected unit is issued (immediate step).
  - The step counter clears and o_fast_set is 0.
- State SET_HR:
  - o_inc_sec keeps following i_1hz_stb.
  - o_inc_hour pulses one cycle after each i_timeset_stb.
- State SET_MIN:
  - o_clr_sec pulses on the entry cycle.
  - o_inc_sec is suppressed.
  - o_inc_min pulses one cycle after each i_timeset_stb.
- Step counter (both set states):
  - Counts the emitted timeset-driven increments, saturating at HOLD_STEPS.
  - When the count equals HOLD_STEPS, o_fast_set goes 1 in the next cycle and stays 1 until the state is left.
- Release of the active button:
  - Return to RUN next cycle; o_fast_set clears and the step counter clears.
  - An i_timeset_stb arriving in the release cycle produces no increment.
- The other button is ignored while in a set state. If it is still held after release, it does not start a new set: only a fresh debounced press does.
- o_setting is 1 exactly while the state is SET_HR or SET_MIN.
- Only one of o_inc_min and o_inc_hour is ever high in a cycle. o_inc_sec may coincide with o_inc_hour.
- Counters never wrap. Debounce saturates at its terminal value and clears.

Decomposition:
- Shared clock package holds:
  - state encoding: RUN=2'd0, SET_HR=2'd1, SET_MIN=2'd2
  - DEBOUNCE_TICKS and HOLD_STEPS defaults
  - REF_CLK_HZ
- Natural sub-module: button_debounce (synchronizer, counter, debounced level, press/release pulses), instantiated twice.
- The FSM and step counter live in the top module.

Test Plan:
1. Reset, then run mode: 3 i_1hz_stb pulses -> 3 o_inc_sec pulses, each 1 cycle late. o_setting=0, o_fast_set=0.
2. Bounce: i_btn_hours toggles every 10 refclk strobes for 200 strobes, then goes low -> no state change, no o_inc_hour.
3. Hours hold: i_btn_hours held high:
   - after 64 refclk strobes -> 1 immediate o_inc_hour
   - then 1 o_inc_hour per i_timeset_stb
   - after 4 such increments, o_fast_set=1
   - release debounced -> state RUN, o_fast_set=0
4. Minutes set: press i_btn_minutes -> o_clr_sec on entry, immediate o_inc_min. Then 2 timeset strobes -> 2 o_inc_min, and 0 o_inc_sec despite 1 Hz strobes.
5. Simultaneous presses of both buttons in the same debounce cycle -> SET_HR only. Release hours while minutes still held -> RUN, no SET_MIN entry.
6. Drop i_en mid-set with o_fast_set=1 -> all strobes 0, state held. Assert i_reset_n low mid-set -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/clock_time_set_ctrl_pkg.sv
// Shared definitions for the clock time-setting controller: state encoding and
// default timing parameters.
package clock_time_set_ctrl_pkg;

    // Reference oscillator feeding the refclk strobe generator.
    localparam int unsigned REF_CLK_HZ = 32768;

    // About 2 ms of stable level at the reference rate (32768 / 512 = 64).
    localparam int unsigned DEBOUNCE_TICKS_DEF = REF_CLK_HZ / 512;

    // Slow-rate set increments before switching the strobe generator to fast.
    localparam int unsigned HOLD_STEPS_DEF = 4;

    // Debounce and step counter width.
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } state_e;

endpackage

// File: rtl/clock_time_set_ctrl_if.sv
// Strobe, button and increment signals between the strobe generator, the
// time-set controller and the time-of-day counters.
interface clock_time_set_ctrl_if;

    logic i_en;
    logic i_refclk_stb;
    logic i_1hz_stb;
    logic i_timeset_stb;
    logic i_btn_hours;
    logic i_btn_minutes;
    logic o_fast_set;
    logic o_inc_sec;
    logic o_inc_min;
    logic o_inc_hour;
    logic o_clr_sec;
    logic o_setting;

    // Environment side: drives strobes and buttons, observes increments.
    modport master (
        output i_en,
        output i_refclk_stb,
        output i_1hz_stb,
        output i_timeset_stb,
        output i_btn_hours,
        output i_btn_minutes,
        input  o_fast_set,
        input  o_inc_sec,
        input  o_inc_min,
        input  o_inc_hour,
        input  o_clr_sec,
        input  o_setting
    );

    // Controller side.
    modport slave (
        input  i_en,
        input  i_refclk_stb,
        input  i_1hz_stb,
        input  i_timeset_stb,
        input  i_btn_hours,
        input  i_btn_minutes,
        output o_fast_set,
        output o_inc_sec,
        output o_inc_min,
        output o_inc_hour,
        output o_clr_sec,
        output o_setting
    );

endinterface

// File: rtl/clock_time_set_ctrl_button_debounce.sv
// Single push-button conditioner: 2-flop synchronizer, refclk-tick debounce
// counter, debounced level and one-cycle press/release pulses.
module clock_time_set_ctrl_button_debounce
    import clock_time_set_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_refclk_stb,
    input  logic i_btn,
    output logic o_press,
    output logic o_release
);

    localparam logic [CNT_W-1:0] LastTick = CNT_W'(DEBOUNCE_TICKS - 1);

    logic [1:0]       sync_q;
    logic             synced;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_prev_q;

    assign synced = sync_q[1];

    // Count refclk ticks while the synced level disagrees; accept it on the last tick.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (synced == level_q) begin
            cnt_d = '0;
        end else if (i_refclk_stb) begin
            if (cnt_q == LastTick) begin
                level_d = synced;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, counter and level registers; frozen while disabled.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q       <= 2'b00;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else if (i_en) begin
            sync_q       <= {sync_q[0], i_btn};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    assign o_press   = level_q & ~level_prev_q;
    assign o_release = ~level_q & level_prev_q;

endmodule

// File: rtl/clock_time_set_ctrl.sv
// Time-set sequencer: debounces the hour/minute buttons and runs the run/set
// mode FSM that issues seconds, minutes and hours increments.
module clock_time_set_ctrl
    import clock_time_set_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int unsigned HOLD_STEPS     = HOLD_STEPS_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF
) (
    input logic                  i_clk,
    input logic                  i_reset_n,
    clock_time_set_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] HoldSteps = CNT_W'(HOLD_STEPS);

    logic hr_press, hr_release;
    logic min_press, min_release;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic             fast_q, fast_d;
    logic             inc_sec_q, inc_sec_d;
    logic             inc_min_q, inc_min_d;
    logic             inc_hour_q, inc_hour_d;
    logic             clr_sec_q, clr_sec_d;

    clock_time_set_ctrl_button_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .CNT_W          (CNT_W)
    ) u_deb_hours (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_en         (bus.i_en),
        .i_refclk_stb (bus.i_refclk_stb),
        .i_btn        (bus.i_btn_hours),
        .o_press      (hr_press),
        .o_release    (hr_release)
    );

    clock_time_set_ctrl_button_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .CNT_W          (CNT_W)
    ) u_deb_minutes (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_en         (bus.i_en),
        .i_refclk_stb (bus.i_refclk_stb),
        .i_btn        (bus.i_btn_minutes),
        .o_press      (min_press),
        .o_release    (min_release)
    );

    // Mode transitions, increment requests and fast-rate step counting.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        fast_d     = fast_q;
        inc_sec_d  = 1'b0;
        inc_min_d  = 1'b0;
        inc_hour_d = 1'b0;
        clr_sec_d  = 1'b0;
        unique case (state_q)
            StRun: begin
                inc_sec_d = bus.i_1hz_stb;
                // Hours takes priority when both presses land together.
                if (hr_press) begin
                    state_d    = StSetHr;
                    inc_hour_d = 1'b1;
                    step_d     = '0;
                    fast_d     = 1'b0;
                end else if (min_press) begin
                    state_d   = StSetMin;
                    inc_min_d = 1'b1;
                    clr_sec_d = 1'b1;
                    step_d    = '0;
                    fast_d    = 1'b0;
                end
            end
            StSetHr: begin
                inc_sec_d = bus.i_1hz_stb;
                if (hr_release) begin
                    // A timeset strobe in the release cycle is dropped.
                    state_d = StRun;
                    step_d  = '0;
                    fast_d  = 1'b0;
                end else begin
                    fast_d = fast_q | (step_q == HoldSteps);
                    if (bus.i_timeset_stb) begin
                        inc_hour_d = 1'b1;
                        if (step_q < HoldSteps) begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
            end
            StSetMin: begin
                // Seconds stay frozen while minutes are being set.
                if (min_release) begin
                    state_d = StRun;
                    step_d  = '0;
                    fast_d  = 1'b0;
                end else begin
                    fast_d = fast_q | (step_q == HoldSteps);
                    if (bus.i_timeset_stb) begin
                        inc_min_d = 1'b1;
                        if (step_q < HoldSteps) begin
                            step_d = step_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StRun;
                step_d  = '0;
                fast_d  = 1'b0;
            end
        endcase
    end

    // State, step counter and output registers; frozen while disabled.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= StRun;
            step_q     <= '0;
            fast_q     <= 1'b0;
            inc_sec_q  <= 1'b0;
            inc_min_q  <= 1'b0;
            inc_hour_q <= 1'b0;
            clr_sec_q  <= 1'b0;
        end else if (bus.i_en) begin
            state_q    <= state_d;
            step_q     <= step_d;
            fast_q     <= fast_d;
            inc_sec_q  <= inc_sec_d;
            inc_min_q  <= inc_min_d;
            inc_hour_q <= inc_hour_d;
            clr_sec_q  <= clr_sec_d;
        end
    end

    // Strobes are masked while disabled so a held register never repeats a pulse.
    assign bus.o_inc_sec  = inc_sec_q & bus.i_en;
    assign bus.o_inc_min  = inc_min_q & bus.i_en;
    assign bus.o_inc_hour = inc_hour_q & bus.i_en;
    assign bus.o_clr_sec  = clr_sec_q & bus.i_en;
    assign bus.o_fast_set = fast_q;
    assign bus.o_setting  = (state_q != StRun);

endmodule

// File: tb/tb_clock_time_set_ctrl.sv
// Self-checking bench for clock_time_set_ctrl: directed scenarios plus a random
// soak, each cycle compared with a behavioural model of the time-set rules.
module tb_clock_time_set_ctrl;

    localparam int DEB  = 64;
    localparam int HOLD = 4;
    localparam int M_RUN = 0;
    localparam int M_HR  = 1;
    localparam int M_MIN = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clock_time_set_ctrl_if bus();

    clock_time_set_ctrl #(
        .DEBOUNCE_TICKS (DEB),
        .HOLD_STEPS     (HOLD),
        .CNT_W          (8)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    bit raw_s1[2], raw_s2[2];
    int db_cnt[2];
    bit db_lvl[2], db_prev[2];
    int mode, steps;
    bit m_fast, m_sec, m_min, m_hour, m_clr;

    // Per-cycle trace bookkeeping
    int    seg_err = 0;
    string seg_msg = "";
    int    cyc = 0;
    int    cnt_sec, cnt_min, cnt_hour, cnt_clr, excl_viol;
    int unsigned hz_pct = 0;
    int unsigned ts_pct = 0;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            raw_s1[b] = 0; raw_s2[b] = 0; db_cnt[b] = 0; db_lvl[b] = 0; db_prev[b] = 0;
        end
        mode = M_RUN; steps = 0;
        m_fast = 0; m_sec = 0; m_min = 0; m_hour = 0; m_clr = 0;
    endfunction

    // One enabled clock edge of the specified behaviour.
    function automatic void model_edge(bit rs, bit hz, bit ts, bit bh, bit bm);
        bit pr[2], rl[2], raw[2];
        raw[0] = bh; raw[1] = bm;
        for (int b = 0; b < 2; b++) begin
            pr[b] = db_lvl[b] && !db_prev[b];
            rl[b] = !db_lvl[b] && db_prev[b];
        end
        m_sec = hz && (mode != M_MIN);
        m_min = 0; m_hour = 0; m_clr = 0;
        if (mode == M_RUN) begin
            if (pr[0]) begin
                mode = M_HR; m_hour = 1; steps = 0; m_fast = 0;
            end else if (pr[1]) begin
                mode = M_MIN; m_min = 1; m_clr = 1; steps = 0; m_fast = 0;
            end
        end else begin
            int own;
            own = (mode == M_HR) ? 0 : 1;
            if (rl[own]) begin
                mode = M_RUN; steps = 0; m_fast = 0;
            end else begin
                if (steps >= HOLD) m_fast = 1;
                if (ts) begin
                    if (mode == M_HR) m_hour = 1;
                    else m_min = 1;
                    if (steps < HOLD) steps = steps + 1;
                end
            end
        end
        for (int b = 0; b < 2; b++) begin
            db_prev[b] = db_lvl[b];
            if (raw_s2[b] == db_lvl[b]) begin
                db_cnt[b] = 0;
            end else if (rs) begin
                db_cnt[b] = db_cnt[b] + 1;
                if (db_cnt[b] == DEB) begin
                    db_lvl[b] = raw_s2[b];
                    db_cnt[b] = 0;
                end
            end
            raw_s2[b] = raw_s1[b];
            raw_s1[b] = raw[b];
        end
    endfunction

    task automatic tick(input bit rs, input bit hz, input bit ts);
        bit [5:0] act, expv;
        bit en;
        bus.i_refclk_stb  = rs;
        bus.i_1hz_stb     = hz;
        bus.i_timeset_stb = ts;
        @(posedge clk);
        en = bus.i_en;
        if (!rst_n) model_reset();
        else if (en) model_edge(rs, hz, ts, bus.i_btn_hours, bus.i_btn_minutes);
        #1;
        cyc++;
        act  = {bus.o_fast_set, bus.o_setting, bus.o_inc_sec, bus.o_inc_min,
                bus.o_inc_hour, bus.o_clr_sec};
        expv = {m_fast, bit'(mode != M_RUN), m_sec & en, m_min & en, m_hour & en, m_clr & en};
        if (act !== expv) begin
            seg_err++;
            if (seg_err == 1)
                seg_msg = $sformatf("cycle %0d {fast,set,sec,min,hr,clr} got %b want %b",
                                    cyc, act, expv);
        end
        cnt_sec  += int'(act[3]);
        cnt_min  += int'(act[2]);
        cnt_hour += int'(act[1]);
        cnt_clr  += int'(act[0]);
        if (act[2] && act[1]) excl_viol++;
    endtask

    function automatic bit rand_rs();
        return ($urandom_range(0, 2) == 0);
    endfunction

    task automatic step_rand();
        bit hz, ts;
        hz = ($urandom_range(0, 99) < hz_pct);
        ts = ($urandom_range(0, 99) < ts_pct);
        tick(rand_rs(), hz, ts);
    endtask

    // Run until n refclk strobes have been issued.
    task automatic strobes(input int n);
        int k;
        k = 0;
        while (k < n) begin
            bit rs, hz, ts;
            rs = rand_rs();
            hz = ($urandom_range(0, 99) < hz_pct);
            ts = ($urandom_range(0, 99) < ts_pct);
            tick(rs, hz, ts);
            if (rs) k++;
        end
    endtask

    task automatic wait_setting(input bit want, input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            step_rand();
            if (bus.o_setting == want) ok = 1;
        end
    endtask

    task automatic clear_counts();
        cnt_sec = 0; cnt_min = 0; cnt_hour = 0; cnt_clr = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        bus.i_en = 1; bus.i_btn_hours = 0; bus.i_btn_minutes = 0;
        model_reset();
        repeat (3) tick(1, 1, 1);
        n_cmp++;
        if (bus.o_setting !== 1'b0 || bus.o_fast_set !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_levels: setting=%b fast=%b, want 0/0", bus.o_setting, bus.o_fast_set);
        end
        n_cmp++;
        if ({bus.o_inc_sec, bus.o_inc_min, bus.o_inc_hour, bus.o_clr_sec} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000",
                     {bus.o_inc_sec, bus.o_inc_min, bus.o_inc_hour, bus.o_clr_sec});
        end
        rst_n = 1;
        repeat (2) tick(0, 0, 0);
        n_cmp++;
        if (seg_err !== 0) begin
            n_fail++; $display("FAIL reset_trace: %0d bad cycles, first %s", seg_err, seg_msg);
        end
        seg_err = 0;
    endtask

    task automatic test_run_mode();
        clear_counts();
        for (int p = 0; p < 3; p++) begin
            repeat (3) tick(rand_rs(), 0, 0);
            tick(rand_rs(), 1, 0);
            n_cmp++;
            if (bus.o_inc_sec !== 1'b1) begin
                n_fail++; $display("FAIL run_sec_latency: pulse %0d inc_sec=%b want 1", p, bus.o_inc_sec);
            end
            tick(rand_rs(), 0, 0);
        end
        n_cmp++;
        if (cnt_sec !== 3) begin
            n_fail++; $display("FAIL run_sec_count: got %0d want 3", cnt_sec);
        end
        n_cmp++;
        if (bus.o_setting !== 1'b0 || bus.o_fast_set !== 1'b0) begin
            n_fail++;
            $display("FAIL run_levels: setting=%b fast=%b want 0/0", bus.o_setting, bus.o_fast_set);
        end
        n_cmp++;
        if (seg_err !== 0) begin
            n_fail++; $display("FAIL run_trace: %0d bad cycles, first %s", seg_err, seg_msg);
        end
        seg_err = 0;
    endtask

    task automatic test_bounce();
        clear_counts();
        hz_pct = 5; ts_pct = 10;
        for (int t = 0; t < 20; t++) begin
            bus.i_btn_hours = ((t % 2) == 0);
            strobes(10);
        end
        bus.i_btn_hours = 0;
        strobes(80);
        n_cmp++;
        if (cnt_hour !== 0 || bus.o_setting !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_reject: inc_hour=%0d setting=%b want 0/0", cnt_hour, bus.o_setting);
        end
        n_cmp++;
        if (seg_err !== 0) begin
            n_fail++; $display("FAIL bounce_trace: %0d bad cycles, first %s", seg_err, seg_msg);
        end
        seg_err = 0;
    endtask

    task automatic test_hours_hold();
        bit ok;
        clear_counts();
        hz_pct = 10; ts_pct = 0;
        bus.i_btn_hours = 1;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step_rand();
            if (cnt_hour != 0) ok = 1;
        end
        n_cmp++;
        if (!ok || cnt_hour !== 1 || bus.o_setting !== 1'b1 || bus.o_fast_set !== 1'b0) begin
            n_fail++;
            $display("FAIL hours_entry: seen=%b inc_hour=%0d setting=%b fast=%b want 1/1/1/0",
                     ok, cnt_hour, bus.o_setting, bus.o_fast_set);
        end
        for (int i = 1; i <= 6; i++) begin
            repeat ($urandom_range(1, 3)) tick(rand_rs(), $urandom_range(0, 3) == 0, 0);
            tick(rand_rs(), 0, 1);
            n_cmp++;
            if (bus.o_inc_hour !== 1'b1) begin
                n_fail++; $display("FAIL hours_step: step %0d inc_hour=%b want 1", i, bus.o_inc_hour);
            end
            if (i == 4) begin
                n_cmp++;
                if (bus.o_fast_set !== 1'b0) begin
                    n_fail++; $display("FAIL hours_fast_early: fast=%b want 0", bus.o_fast_set);
                end
            end
            tick(rand_rs(), 0, 0);
            if (i == 4) begin
                n_cmp++;
                if (bus.o_fast_set !== 1'b1) begin
                    n_fail++; $display("FAIL hours_fast_on: fast=%b want 1", bus.o_fast_set);
                end
            end
        end
        n_cmp++;
        if (cnt_hour !== 7) begin
            n_fail++; $display("FAIL hours_count: got %0d want 7", cnt_hour);
        end
        ts_pct = 10;
        bus.i_btn_hours = 0;
        wait_setting(0, 2000, ok);
        n_cmp++;
        if (!ok || bus.o_fast_set !== 1'b0) begin
            n_fail++;
            $display("FAIL hours_release: back_to_run=%b fast=%b want 1/0", ok, bus.o_fast_set);
        end
        ts_pct = 0;
        n_cmp++;
        if (seg_err !== 0) begin
            n_fail++; $display("FAIL hours_trace: %0d bad cycles, first %s", seg_err, seg_msg);
        end
        seg_err = 0;
    endtask

    task automatic test_minutes_set();
        bit ok;
        hz_pct = 0; ts_pct = 0;
        clear_counts();
        bus.i_btn_minutes = 1;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            tick(rand_rs(), 0, 0);
            if (bus.o_clr_sec) ok = 1;
        end
        n_cmp++;
        if (!ok || bus.o_inc_min !== 1'b1 || bus.o_inc_hour !== 1'b0 || bus.o_setting !== 1'b1) begin
            n_fail++;
            $display("FAIL minutes_entry: clr=%b inc_min=%b inc_hour=%b setting=%b want 1/1/0/1",
                     ok, bus.o_inc_min, bus.o_inc_hour, bus.o_setting);
        end
        clear_counts();
        for (int i = 0; i < 2; i++) begin
            tick(rand_rs(), 1, 0);
            tick(rand_rs(), 0, 1);
            n_cmp++;
            if (bus.o_inc_min !== 1'b1) begin
                n_fail++; $display("FAIL minutes_step: step %0d inc_min=%b want 1", i, bus.o_inc_min);
            end
            tick(rand_rs(), 1, 0);
        end
        n_cmp++;
        if (cnt_min !== 2 || cnt_sec !== 0 || cnt_clr !== 0) begin
            n_fail++;
            $display("FAIL minutes_counts: inc_min=%0d inc_sec=%0d clr=%0d want 2/0/0",
                     cnt_min, cnt_sec, cnt_clr);
        end
        bus.i_btn_minutes = 0;
        wait_setting(0, 2000, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL minutes_release: setting=%b want 0", bus.o_setting);
        end
        n_cmp++;
        if (seg_err !== 0) begin
            n_fail++; $display("FAIL minutes_trace: %0d bad cycles, first %s", seg_err, seg_msg);
        end
        seg_err = 0;
    endtask

    task automatic test_simultaneous();
        bit ok;
        hz_pct = 10; ts_pct = 0;
        clear_counts();
        bus.i_btn_hours = 1;
        bus.i_btn_minutes = 1;
        wait_setting(1, 2000, ok);
        n_cmp++;
        if (!ok || cnt_hour !== 1 || cnt_min !== 0 || cnt_clr !== 0) begin
            n_fail++;
            $display("FAIL simul_entry: set=%b inc_hour=%0d inc_min=%0d clr=%0d want 1/1/0/0",
                     ok, cnt_hour, cnt_min, cnt_clr);
        end
        bus.i_btn_hours = 0;
        wait_setting(0, 2000, ok);
        clear_counts();
        strobes(150);
        n_cmp++;
        if (!ok || bus.o_setting !== 1'b0 || cnt_min !== 0 || cnt_clr !== 0) begin
            n_fail++;
            $display("FAIL simul_no_min: released=%b setting=%b inc_min=%0d clr=%0d want 1/0/0/0",
                     ok, bus.o_setting, cnt_min, cnt_clr);
        end
        bus.i_btn_minutes = 0;
        strobes(80);
        n_cmp++;
        if (seg_err !== 0) begin
            n_fail++; $display("FAIL simul_trace: %0d bad cycles, first %s", seg_err, seg_msg);
        end
        seg_err = 0;
    endtask

    task automatic test_enable_reset();
        bit ok;
        hz_pct = 10; ts_pct = 0;
        bus.i_btn_hours = 1;
        wait_setting(1, 2000, ok);
        for (int i = 0; i < 5; i++) begin
            tick(rand_rs(), 0, 1);
            tick(rand_rs(), 0, 0);
        end
        tick(0, 0, 0);
        n_cmp++;
        if (!ok || bus.o_fast_set !== 1'b1) begin
            n_fail++; $display("FAIL en_setup: set=%b fast=%b want 1/1", ok, bus.o_fast_set);
        end
        bus.i_en = 0;
        hz_pct = 50; ts_pct = 50;
        clear_counts();
        repeat (40) step_rand();
        n_cmp++;
        if (cnt_sec + cnt_min + cnt_hour + cnt_clr !== 0) begin
            n_fail++;
            $display("FAIL en_strobes: %0d strobes while disabled, want 0",
                     cnt_sec + cnt_min + cnt_hour + cnt_clr);
        end
        n_cmp++;
        if (bus.o_setting !== 1'b1 || bus.o_fast_set !== 1'b1) begin
            n_fail++;
            $display("FAIL en_hold: setting=%b fast=%b want 1/1", bus.o_setting, bus.o_fast_set);
        end
        bus.i_en = 1;
        hz_pct = 0; ts_pct = 0;
        repeat (2) tick(0, 0, 0);
        // Assert reset between clock edges and look before the next edge.
        rst_n = 0;
        #1;
        n_cmp++;
        if ({bus.o_fast_set, bus.o_setting, bus.o_inc_sec, bus.o_inc_min, bus.o_inc_hour,
             bus.o_clr_sec} !== 6'b000000) begin
            n_fail++;
            $display("FAIL async_reset: outputs %b want 000000",
                     {bus.o_fast_set, bus.o_setting, bus.o_inc_sec, bus.o_inc_min,
                      bus.o_inc_hour, bus.o_clr_sec});
        end
        model_reset();
        bus.i_btn_hours = 0;
        repeat (3) tick(1, 1, 1);
        rst_n = 1;
        repeat (5) tick(rand_rs(), 0, 0);
        n_cmp++;
        if (seg_err !== 0) begin
            n_fail++; $display("FAIL en_reset_trace: %0d bad cycles, first %s", seg_err, seg_msg);
        end
        seg_err = 0;
    endtask

    task automatic test_back_to_back();
        excl_viol = 0;
        hz_pct = 10; ts_pct = 15;
        for (int s = 0; s < 30; s++) begin
            bus.i_btn_hours   = ($urandom_range(0, 2) == 0);
            bus.i_btn_minutes = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) begin
                bus.i_en = 0;
                repeat ($urandom_range(2, 12)) step_rand();
                bus.i_en = 1;
            end
            strobes($urandom_range(20, 120));
        end
        bus.i_btn_hours = 0;
        bus.i_btn_minutes = 0;
        strobes(150);
        n_cmp++;
        if (excl_viol !== 0) begin
            n_fail++; $display("FAIL random_exclusive: %0d cycles with min and hour, want 0", excl_viol);
        end
        n_cmp++;
        if (seg_err !== 0) begin
            n_fail++; $display("FAIL random_trace: %0d bad cycles, first %s", seg_err, seg_msg);
        end
        seg_err = 0;
    endtask

    initial begin
        bus.i_en = 1;
        bus.i_refclk_stb = 0;
        bus.i_1hz_stb = 0;
        bus.i_timeset_stb = 0;
        bus.i_btn_hours = 0;
        bus.i_btn_minutes = 0;
        model_reset();
        clear_counts();
        excl_viol = 0;
        test_reset();
        test_run_mode();
        test_bounce();
        test_hours_hold();
        test_minutes_set();
        test_simultaneous();
        test_enable_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
